// File: rtl/route_sched.sv
// route_sched: multi-stop route scheduler between the host UART receiver and
// the robot command controller. Host bytes append station IDs to a route
// queue, start the route or abort it. One GO is dispatched per stop, the block
// waits for arrival (in_transit falling) and then dwells before the next stop.
//
// Optional build macro: ROUTE_LOOP_EN
//   defined   - every dispatched ID is re-queued at the tail, so the route
//               repeats until a host STOP.
//   undefined - dispatched IDs are discarded and the route ends when the
//               queue drains.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no route active, waiting for START with a non-empty queue
// ISSUE    | pop head of queue, register GO command (one cycle)
// WAIT_ACK | GO held on cmd/cmd_rdy until controller accepts it
// WAIT_GO  | GO accepted, waiting for controller to report in_transit
// TRANSIT  | robot moving, waiting for in_transit to fall (arrival)
// DWELL    | counting down the dwell time at the reached station
// ABORT    | STOP held on cmd/cmd_rdy until controller accepts it
module route_sched #(
    parameter int DEPTH     = 8,
    parameter int DWELL_CYC = 50000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_rdy,
    output logic                     clr_rx_rdy,
    output logic [7:0]               cmd,
    output logic                     cmd_rdy,
    input  logic                     clr_cmd_rdy,
    input  logic                     in_transit,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     ovfl
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYC - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_WAIT_GO  = 3'd3;
    localparam logic [2:0] S_TRANSIT  = 3'd4;
    localparam logic [2:0] S_DWELL    = 3'd5;
    localparam logic [2:0] S_ABORT    = 3'd6;

    logic [2:0]    state;
    logic [DW-1:0] dwell_cnt;

    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          host_stop;
    logic          host_append;
    logic          host_start;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          drop;
    logic [5:0]    head;
    logic [5:0]    push_data;

    // Every host byte is consumed in the cycle it is presented.
    assign clr_rx_rdy  = rx_rdy;

    assign host_stop   = rx_rdy && (rx_data[7:6] == 2'b00);
    assign host_append = rx_rdy && (rx_data[7:6] == 2'b01);
    assign host_start  = rx_rdy && (rx_data[7:6] == 2'b10);

    assign fifo_full   = (q_count == CW'(DEPTH));
    assign fifo_empty  = (q_count == '0);
    assign head        = mem[rd_ptr];
    assign busy        = (state != S_IDLE);

    // A STOP in ISSUE cancels the pop; the flush empties the queue anyway.
    assign pop         = (state == S_ISSUE) && !host_stop;

`ifdef ROUTE_LOOP_EN
    // The re-push of the dispatched ID owns the write port in the ISSUE
    // cycle, so a host APPEND arriving then is dropped.
    logic loop_push;
    logic host_push;
    assign loop_push = pop;
    assign host_push = host_append && (state != S_ISSUE) && !fifo_full;
    assign push      = loop_push || host_push;
    assign drop      = host_append && ((state == S_ISSUE) || fifo_full);
    assign push_data = loop_push ? head : rx_data[5:0];
`else
    // A same-cycle pop frees a slot, so a push into a full queue succeeds.
    assign push      = host_append && (!fifo_full || pop);
    assign drop      = host_append && fifo_full && !pop;
    assign push_data = rx_data[5:0];
`endif

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Queue pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
            ovfl    <= 1'b0;
        end else if (host_stop) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
            ovfl    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + CW'(1);
                2'b01:   q_count <= q_count - CW'(1);
                default: q_count <= q_count;
            endcase
            if (drop) begin
                ovfl <= 1'b1;
            end
        end
    end

    // Route sequencing FSM with registered command outputs and dwell timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd       <= 8'h00;
            cmd_rdy   <= 1'b0;
            dwell_cnt <= '0;
        end else if (host_stop) begin
            // STOP wins over whatever transition this cycle would have taken.
            if (state != S_IDLE) begin
                cmd     <= 8'h00;
                cmd_rdy <= 1'b1;
                state   <= S_ABORT;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_rdy <= 1'b0;
                    if (host_start && !fifo_empty) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cmd     <= {2'b01, head};
                    cmd_rdy <= 1'b1;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (clr_cmd_rdy) begin
                        cmd_rdy <= 1'b0;
                        state   <= S_WAIT_GO;
                    end
                end
                S_WAIT_GO: begin
                    // Controller registers the GO before raising in_transit.
                    if (in_transit) begin
                        state <= S_TRANSIT;
                    end
                end
                S_TRANSIT: begin
                    if (!in_transit) begin
                        dwell_cnt <= DWELL_LOAD;
                        state     <= S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (dwell_cnt == '0) begin
                        state <= fifo_empty ? S_IDLE : S_ISSUE;
                    end else begin
                        dwell_cnt <= dwell_cnt - DW'(1);
                    end
                end
                S_ABORT: begin
                    if (clr_cmd_rdy) begin
                        cmd_rdy <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    cmd_rdy <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_route_sched.sv
// Testbench for route_sched: stimulus table, directed multi-cycle sequences
// and randomized traffic, all checked against a queue-based reference model
// that is stepped once per clock.
module tb_route_sched;

    localparam int DEPTH = 8;
    localparam int DWELL = 10;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_ACK   = 2;
    localparam int P_GO    = 3;
    localparam int P_MOVE  = 4;
    localparam int P_DWELL = 5;
    localparam int P_ABORT = 6;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       clr_rx_rdy;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic       in_transit;
    logic       busy;
    logic [3:0] q_count;
    logic       ovfl;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    int         m_ph;
    logic [5:0] m_q[$];
    logic       m_ovfl;
    logic [7:0] m_cmd;
    logic       m_rdy;
    int         m_dwell;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        int         exp_q;
        logic       exp_ovfl;
        logic       exp_busy;
    } vec_t;

    vec_t tbl[16];
    int   n_tbl;

    route_sched #(.DEPTH(DEPTH), .DWELL_CYC(DWELL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .in_transit  (in_transit),
        .busy        (busy),
        .q_count     (q_count),
        .ovfl        (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph    = P_IDLE;
        m_q.delete();
        m_ovfl  = 1'b0;
        m_cmd   = 8'h00;
        m_rdy   = 1'b0;
        m_dwell = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic       stop;
        logic       app;
        logic       start;
        logic [5:0] h;
        bit         issuing;
        stop    = rx_rdy && (rx_data[7:6] == 2'b00);
        app     = rx_rdy && (rx_data[7:6] == 2'b01);
        start   = rx_rdy && (rx_data[7:6] == 2'b10);
        issuing = 0;
        if (stop) begin
            m_q.delete();
            m_ovfl = 1'b0;
            if (m_ph != P_IDLE) begin
                m_cmd = 8'h00;
                m_rdy = 1'b1;
                m_ph  = P_ABORT;
            end
            return;
        end
        case (m_ph)
            P_IDLE:  if (start && m_q.size() > 0) m_ph = P_ISSUE;
            P_ISSUE: begin
                h     = m_q.pop_front();
                m_cmd = {2'b01, h};
                m_rdy = 1'b1;
`ifdef ROUTE_LOOP_EN
                m_q.push_back(h);
`endif
                issuing = 1;
                m_ph    = P_ACK;
            end
            P_ACK:   if (clr_cmd_rdy) begin m_rdy = 1'b0; m_ph = P_GO; end
            P_GO:    if (in_transit) m_ph = P_MOVE;
            P_MOVE:  if (!in_transit) begin m_dwell = DWELL - 1; m_ph = P_DWELL; end
            P_DWELL: begin
                if (m_dwell == 0) m_ph = (m_q.size() > 0) ? P_ISSUE : P_IDLE;
                else m_dwell--;
            end
            P_ABORT: if (clr_cmd_rdy) begin m_rdy = 1'b0; m_ph = P_IDLE; end
            default: m_ph = P_IDLE;
        endcase
        if (app) begin
`ifdef ROUTE_LOOP_EN
            if (issuing) m_ovfl = 1'b1;
            else
`endif
            if (m_q.size() < DEPTH) m_q.push_back(rx_data[5:0]);
            else m_ovfl = 1'b1;
        end
    endtask

    // One clock: step the model, take the edge, compare all outputs.
    task automatic tick();
        logic [15:0] act;
        logic [15:0] exp;
        model_step();
        @(posedge clk);
        #1;
        act = {cmd, cmd_rdy, busy, q_count, ovfl, clr_rx_rdy};
        exp = {m_cmd, m_rdy, (m_ph != P_IDLE), 4'(m_q.size()), m_ovfl, rx_rdy};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle: cmd=%h rdy=%b busy=%b q=%0d ovfl=%b clr_rx=%b expected cmd=%h rdy=%b busy=%b q=%0d ovfl=%b clr_rx=%b at %0t",
                     cmd, cmd_rdy, busy, q_count, ovfl, clr_rx_rdy,
                     m_cmd, m_rdy, (m_ph != P_IDLE), m_q.size(), m_ovfl, rx_rdy, $time);
        end
    endtask

    task automatic host(input logic [7:0] b);
        rx_rdy  = 1'b1;
        rx_data = b;
        tick();
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic do_reset();
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
        in_transit  = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #3;
        check("rst_cmd", cmd, 8'h00);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_q_count", q_count, 0);
        check("rst_ovfl", ovfl, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_rdy(input int limit);
        for (int i = 0; i < limit && cmd_rdy !== 1'b1; i++) tick();
        check("wait_cmd_rdy", cmd_rdy, 1);
    endtask

    // Controller emulation for one stop: accept GO, move, arrive.
    task automatic serve(input logic [7:0] exp_cmd, input int transit);
        wait_rdy(60);
        check("go_cmd", cmd, exp_cmd);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        in_transit  = 1'b1;
        repeat (transit) tick();
        in_transit  = 1'b0;
    endtask

    initial begin
        int k;

        // ---------------- table: queueing, overflow, STOP in IDLE
        n_tbl = 0;
        for (int i = 0; i < 9; i++) begin
            tbl[n_tbl] = '{1'b1, 8'(8'h41 + i), (i < 8) ? i + 1 : 8, (i == 8), 1'b0};
            n_tbl++;
        end
        tbl[n_tbl++] = '{1'b1, 8'hC5, 8, 1'b1, 1'b0};   // opcode 11 ignored
        tbl[n_tbl++] = '{1'b1, 8'h00, 0, 1'b0, 1'b0};   // STOP in IDLE
        tbl[n_tbl++] = '{1'b1, 8'h80, 0, 1'b0, 1'b0};   // START on empty
        tbl[n_tbl++] = '{1'b1, 8'h4A, 1, 1'b0, 1'b0};
        tbl[n_tbl++] = '{1'b0, 8'h4B, 1, 1'b0, 1'b0};   // not valid
        tbl[n_tbl++] = '{1'b1, 8'h3F, 0, 1'b0, 1'b0};   // STOP with ID bits

        do_reset();
        for (int i = 0; i < n_tbl; i++) begin
            rx_rdy  = tbl[i].vld;
            rx_data = tbl[i].data;
            #1;
            check("tbl_clr_rx_rdy", clr_rx_rdy, tbl[i].vld);
            tick();
            rx_rdy  = 1'b0;
            rx_data = 8'h00;
            check("tbl_q_count", q_count, tbl[i].exp_q);
            check("tbl_ovfl", ovfl, tbl[i].exp_ovfl);
            check("tbl_busy", busy, tbl[i].exp_busy);
            check("tbl_cmd_rdy", cmd_rdy, 0);
        end

        // ---------------- queue and dispatch with dwell timing
        do_reset();
        host(8'h45);
        host(8'h4A);
        host(8'h80);
        tick();
        check("start_latency", cmd_rdy, 1);
        serve(8'h45, 20);
        check("q_after_first", q_count, 1);
        k = 0;
        for (int i = 0; i < 100 && cmd_rdy !== 1'b1; i++) begin tick(); k++; end
        check("dwell_to_next_go", k, DWELL + 2);
        serve(8'h4A, 20);
        k = 0;
        for (int i = 0; i < 100 && busy !== 1'b0; i++) begin tick(); k++; end
        check("dwell_to_idle", k, DWELL + 1);
        check("final_q_count", q_count, 0);

`ifndef ROUTE_LOOP_EN
        // ---------------- overflowed entry is never dispatched
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) host(8'(8'h41 + i));
        check("ovf_q_count", q_count, 8);
        check("ovf_flag", ovfl, 1);
        host(8'h80);
        for (int i = 0; i < DEPTH; i++) serve(8'(8'h41 + i), 3);
        for (int i = 0; i < 60 && busy !== 1'b0; i++) tick();
        check("ovf_drained_busy", busy, 0);
        repeat (10) tick();
        check("ovf_no_extra_go", cmd_rdy, 0);
        check("ovf_last_cmd", cmd, 8'h48);
`endif

        // ---------------- abort in transit
        do_reset();
        host(8'h41);
        host(8'h42);
        host(8'h43);
        host(8'h80);
        wait_rdy(10);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        in_transit  = 1'b1;
        repeat (5) tick();
        host(8'h00);
        check("abort_cmd", cmd, 8'h00);
        check("abort_rdy", cmd_rdy, 1);
        check("abort_q", q_count, 0);
        in_transit = 1'b0;
        repeat (4) tick();
        check("abort_rdy_held", cmd_rdy, 1);
        check("abort_busy_held", busy, 1);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_rdy_drop", cmd_rdy, 0);

        // ---------------- STOP replaces a pending GO
        do_reset();
        host(8'h44);
        host(8'h45);
        host(8'h80);
        wait_rdy(10);
        check("wack_go", cmd, 8'h44);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wack_rdy_hold", cmd_rdy, 1);
        end
        host(8'h00);
        check("wack_stop_cmd", cmd, 8'h00);
        check("wack_stop_rdy", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check("wack_idle", busy, 0);

        // ---------------- APPEND in the ISSUE cycle with a full queue
        do_reset();
        for (int i = 0; i < DEPTH; i++) host(8'(8'h41 + i));
        host(8'h80);
        host(8'h4F);
        check("pp_q_count", q_count, 8);
`ifdef ROUTE_LOOP_EN
        check("pp_ovfl", ovfl, 1);
        host(8'h00);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
`else
        check("pp_ovfl", ovfl, 0);
        for (int i = 0; i < DEPTH - 1; i++) serve(8'(8'h41 + i), 2);
        serve(8'h48, 2);
        serve(8'h4F, 2);
        for (int i = 0; i < 60 && busy !== 1'b0; i++) tick();
        check("pp_drained", busy, 0);
`endif

`ifdef ROUTE_LOOP_EN
        // ---------------- loop mode keeps cycling the route
        do_reset();
        host(8'h41);
        host(8'h42);
        host(8'h80);
        for (int i = 0; i < 5; i++) begin
            serve((i % 2 == 0) ? 8'h41 : 8'h42, 3);
            check("loop_q_count", q_count, 2);
        end
        host(8'h00);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check("loop_stopped", busy, 0);
`endif

        // ---------------- async reset mid-route
        do_reset();
        host(8'h41);
        host(8'h42);
        host(8'h80);
        wait_rdy(10);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        in_transit  = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_q", q_count, 0);
        check("arst_cmd", cmd, 8'h00);
        do_reset();
        host(8'h80);
        tick();
        check("arst_queue_lost", busy, 0);

        // ---------------- randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 25) begin
                int op;
                op = $urandom_range(0, 99);
                rx_rdy = 1'b1;
                rx_data[5:0] = 6'($urandom);
                rx_data[7:6] = (op < 5) ? 2'b00 : (op < 55) ? 2'b01 : (op < 85) ? 2'b10 : 2'b11;
            end else begin
                rx_rdy  = 1'b0;
                rx_data = 8'($urandom);
            end
            clr_cmd_rdy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) in_transit = ~in_transit;
            tick();
        end
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        in_transit  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
